// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA prime-pair front end.
//   CAND_W     : width of candidates and of the LFSR
//   LFSR_TAPS  : feedback taps of the 8-bit Fibonacci LFSR (bits 7,5,4,3)
//   state_t    : prime_pair_gen FSM states
//   try_width  : width of a counter that must reach max_tries, capped at 8
package rsa_pkg;

    localparam int CAND_W = 8;

    localparam logic [CAND_W-1:0] LFSR_TAPS = 8'b1011_1000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DONE,
        S_FAIL
    } state_t;

    function automatic int try_width(input int max_tries);
        int w;
        w = $clog2(max_tries + 1);
        if (w > 8) w = 8;
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/prime_pair_gen_if.sv
// Start/finish handshake between the prime-pair generator and the
// primality checker.
//   chk_start    : one-cycle request pulse (generator -> checker)
//   chk_num      : candidate, stable while the check is outstanding
//   chk_finish   : completion pulse (checker -> generator)
//   chk_is_prime : verdict, meaningful only with chk_finish
interface prime_pair_gen_if;

    logic                        chk_start;
    logic [rsa_pkg::CAND_W-1:0]  chk_num;
    logic                        chk_finish;
    logic                        chk_is_prime;

    modport master (
        output chk_start,
        output chk_num,
        input  chk_finish,
        input  chk_is_prime
    );

    modport slave (
        input  chk_start,
        input  chk_num,
        output chk_finish,
        output chk_is_prime
    );

endinterface

// File: rtl/prime_lfsr8.sv
// 8-bit Fibonacci LFSR used as the candidate source.
//   clk, rst_n  : clock, asynchronous active-low reset (loads SEED)
//   load        : load load_val (caller guarantees it is nonzero)
//   step        : advance one step; load has priority
//   lfsr_state  : current register contents
module prime_lfsr8
    import rsa_pkg::*;
#(
    parameter logic [CAND_W-1:0] SEED = 8'hB5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [CAND_W-1:0] load_val,
    input  logic              step,
    output logic [CAND_W-1:0] lfsr_state
);

    // An all-zero LFSR would lock up, so a zero SEED is replaced by 1.
    localparam logic [CAND_W-1:0] SEED_EFF = (SEED == '0) ? 8'h01 : SEED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_state <= SEED_EFF;
        end else if (load) begin
            lfsr_state <= load_val;
        end else if (step) begin
            lfsr_state <= {lfsr_state[CAND_W-2:0], ^(lfsr_state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/prime_pair_gen.sv
// Finds two distinct 8-bit primes for RSA key generation by drawing odd
// candidates from an LFSR and stepping by +2 through an external checker.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start, seed      : request pulse; nonzero seed reloads the LFSR
//   busy, done, fail : request status (done/fail are one-cycle pulses)
//   p, q, tries      : results, held until the next done (tries also on fail)
//   chk              : handshake to the primality checker
module prime_pair_gen
    import rsa_pkg::*;
#(
    parameter logic [CAND_W-1:0] SEED      = 8'hB5,
    parameter int                MAX_TRIES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CAND_W-1:0]    seed,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [CAND_W-1:0]    p,
    output logic [CAND_W-1:0]    q,
    output logic [7:0]           tries,
    prime_pair_gen_if.master     chk
);

    localparam int               TRY_W     = try_width(MAX_TRIES);
    localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);

    state_t              state, state_nxt;
    logic                sel;
    logic [CAND_W-1:0]   cand;
    logic [CAND_W-1:0]   p_found;
    logic [TRY_W-1:0]    try_cnt;
    logic [CAND_W-1:0]   lfsr;
    logic                lfsr_load, lfsr_step;
    logic                accept, collide, exhausted, issue;
    logic                unused_lfsr_bits;

    prime_lfsr8 #(.SEED(SEED)) u_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (lfsr_load),
        .load_val   (seed),
        .step       (lfsr_step),
        .lfsr_state (lfsr)
    );

    // Candidate uses only lfsr[6:1]; the outer bits are forced to 1.
    assign unused_lfsr_bits = lfsr[7] ^ lfsr[0];

    // busy is already low in DONE/FAIL, so a start there is accepted too.
    assign accept    = start && (state == S_IDLE || state == S_DONE || state == S_FAIL);
    // Second prime must differ from the first: skip p_found without a check.
    assign collide   = sel && (cand == p_found);
    assign exhausted = (try_cnt == TRY_LIMIT);

    assign chk.chk_start = issue;
    assign chk.chk_num   = cand;

    always_comb begin
        state_nxt = state;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        issue     = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_FAIL: begin
                state_nxt = S_IDLE;
                if (accept) begin
                    state_nxt = S_DRAW;
                    lfsr_load = (seed != '0);
                end
            end
            S_DRAW: begin
                lfsr_step = 1'b1;
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (collide) begin
                    state_nxt = S_NEXT;
                end else if (exhausted) begin
                    state_nxt = S_FAIL;
                end else begin
                    issue     = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (chk.chk_finish) begin
                    if (!chk.chk_is_prime) state_nxt = S_NEXT;
                    else if (sel)          state_nxt = S_DONE;
                    else                   state_nxt = S_DRAW;
                end
            end
            // 255 + 2 would wrap; draw a fresh candidate instead.
            S_NEXT:  state_nxt = (cand == 8'hFF) ? S_DRAW : S_ISSUE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            sel     <= 1'b0;
            cand    <= '0;
            p_found <= '0;
            try_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            fail    <= 1'b0;
            p       <= '0;
            q       <= '0;
            tries   <= '0;
        end else begin
            state <= state_nxt;
            // Status registers follow the next state so done/fail line up
            // with the DONE/FAIL cycle and busy drops on the same edge.
            busy  <= !(state_nxt inside {S_IDLE, S_DONE, S_FAIL});
            done  <= (state_nxt == S_DONE);
            fail  <= (state_nxt == S_FAIL);

            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (accept) begin
                        try_cnt <= '0;
                        sel     <= 1'b0;
                    end
                end
                S_DRAW:  cand <= {1'b1, lfsr[6:1], 1'b1};
                S_ISSUE: if (issue) try_cnt <= try_cnt + TRY_W'(1);
                S_WAIT: begin
                    if (chk.chk_finish && chk.chk_is_prime && !sel) begin
                        p_found <= cand;
                        sel     <= 1'b1;
                    end
                end
                S_NEXT:  if (cand != 8'hFF) cand <= cand + 8'd2;
                default: ;
            endcase

            if (state_nxt == S_DONE) begin
                p     <= p_found;
                q     <= cand;
                tries <= 8'(try_cnt);
            end else if (state_nxt == S_FAIL) begin
                tries <= 8'(try_cnt);
            end
        end
    end

endmodule

// File: tb/tb_prime_pair_gen.sv
// Self-checking bench for prime_pair_gen: a trial-division checker model,
// directed scenarios and randomized seeds compared to an algorithmic model.
module tb_prime_pair_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] seed = 8'h00;
    logic       busy, done, fail;
    logic [7:0] p, q, tries;

    logic       start_f = 1'b0;
    logic [7:0] seed_f = 8'h00;
    logic       busy_f, done_f, fail_f;
    logic [7:0] p_f, q_f, tries_f;

    int n_checks = 0;
    int n_errors = 0;

    prime_pair_gen_if ifc ();
    prime_pair_gen_if ifc_f ();

    prime_pair_gen #(.SEED(8'hB5), .MAX_TRIES(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
        .busy(busy), .done(done), .fail(fail),
        .p(p), .q(q), .tries(tries), .chk(ifc.master)
    );

    prime_pair_gen #(.SEED(8'hB5), .MAX_TRIES(4)) dut_f (
        .clk(clk), .rst_n(rst_n), .start(start_f), .seed(seed_f),
        .busy(busy_f), .done(done_f), .fail(fail_f),
        .p(p_f), .q(q_f), .tries(tries_f), .chk(ifc_f.master)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++)
            if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    // ---------------- checker models ----------------
    localparam int LAT = 5;
    int   issued[$];
    logic [7:0] pend_num;
    bit   pend = 1'b0;
    int   wait_cnt = 0;

    initial begin
        ifc.chk_finish   = 1'b0;
        ifc.chk_is_prime = 1'b0;
        forever begin
            @(negedge clk);
            if (ifc.chk_finish) begin
                ifc.chk_finish   = 1'b0;
                ifc.chk_is_prime = 1'b0;
            end
            if (!rst_n) begin
                pend = 1'b0;
            end else if (ifc.chk_start) begin
                pend     = 1'b1;
                pend_num = ifc.chk_num;
                wait_cnt = LAT;
                issued.push_back(int'(ifc.chk_num));
            end else if (pend) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    check_eq("chk_num_hold", ifc.chk_num, pend_num);
                    ifc.chk_finish   = 1'b1;
                    ifc.chk_is_prime = is_prime(int'(pend_num));
                    pend = 1'b0;
                end
            end
        end
    end

    int  n_starts_f = 0;
    bit  pend_f = 1'b0;
    int  wait_f = 0;

    initial begin
        ifc_f.chk_finish   = 1'b0;
        ifc_f.chk_is_prime = 1'b0;
        forever begin
            @(negedge clk);
            if (ifc_f.chk_finish) ifc_f.chk_finish = 1'b0;
            if (!rst_n) begin
                pend_f = 1'b0;
            end else if (ifc_f.chk_start) begin
                pend_f = 1'b1;
                wait_f = 3;
                n_starts_f++;
            end else if (pend_f) begin
                wait_f--;
                if (wait_f == 0) begin
                    ifc_f.chk_finish = 1'b1;
                    pend_f = 1'b0;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] m_lfsr = 8'hB5;
    int         exp_seq[$];
    logic [7:0] last_p = 8'h00;
    logic [7:0] last_q = 8'h00;

    task automatic model_req(input logic [7:0] sd, input int max_t,
                             output bit ok, output logic [7:0] mp, output logic [7:0] mq,
                             output int mt);
        logic [7:0] c;
        logic [7:0] found [2];
        bit hit;
        exp_seq.delete();
        found[0] = 8'h00;
        found[1] = 8'h00;
        if (sd != 8'h00) m_lfsr = sd;
        mt = 0; ok = 1'b0; mp = last_p; mq = last_q;
        for (int tgt = 0; tgt < 2; tgt++) begin
            hit = 1'b0;
            while (!hit) begin
                c = {1'b1, m_lfsr[6:1], 1'b1};
                m_lfsr = lfsr_next(m_lfsr);
                while (1) begin
                    if (!(tgt == 1 && c == found[0])) begin
                        if (mt == max_t) return;
                        mt++;
                        exp_seq.push_back(int'(c));
                        if (is_prime(int'(c))) begin
                            found[tgt] = c;
                            hit = 1'b1;
                            break;
                        end
                    end
                    if (c == 8'hFF) break;
                    c = c + 8'd2;
                end
            end
        end
        ok = 1'b1; mp = found[0]; mq = found[1];
    endtask

    // Runs one request on the main DUT; optionally pulses a stray start
    // with another seed while the request is in flight.
    task automatic do_req(input logic [7:0] sd, input string tag, input bit inject,
                          input bit props);
        bit ok; logic [7:0] mp, mq; int mt; int cyc;
        model_req(sd, 64, ok, mp, mq, mt);
        issued.delete();
        @(negedge clk); start = 1'b1; seed = sd;
        @(negedge clk); start = 1'b0; seed = 8'h00;
        check_eq({tag, "_busy_rise"}, busy, 1'b1);
        if (inject) begin
            repeat (6) @(negedge clk);
            start = 1'b1; seed = 8'h33;
            @(negedge clk); start = 1'b0; seed = 8'h00;
        end
        cyc = 0;
        while (!done && !fail && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_timeout"}, cyc >= 5000, 1'b0);
        check_eq({tag, "_done"}, done, ok);
        check_eq({tag, "_fail"}, fail, !ok);
        check_eq({tag, "_busy_end"}, busy, 1'b0);
        check_eq({tag, "_p"}, p, mp);
        check_eq({tag, "_q"}, q, mq);
        check_eq({tag, "_tries"}, tries, mt);
        check_eq({tag, "_nchk"}, issued.size(), exp_seq.size());
        for (int i = 0; i < issued.size() && i < exp_seq.size(); i++)
            check_eq($sformatf("%s_seq%0d", tag, i), issued[i], exp_seq[i]);
        if (props && ok) begin
            check_eq({tag, "_p_prime"}, is_prime(int'(p)), 1'b1);
            check_eq({tag, "_q_prime"}, is_prime(int'(q)), 1'b1);
            check_eq({tag, "_p_ne_q"}, p != q, 1'b1);
            check_eq({tag, "_range"}, (p >= 129 && p <= 251 && q >= 129 && q <= 251), 1'b1);
        end
        if (ok) begin last_p = mp; last_q = mq; end
        @(negedge clk);
        check_eq({tag, "_pulse_end"}, done | fail, 1'b0);
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_fail", fail, 1'b0);
        check_eq("rst_p", p, 8'd0);
        check_eq("rst_q", q, 8'd0);
        check_eq("rst_tries", tries, 8'd0);
        check_eq("rst_chk_start", ifc.chk_start, 1'b0);
        check_eq("rst_chk_num", ifc.chk_num, 8'd0);
        check_eq("rst_lfsr", dut.u_lfsr.lfsr_state, 8'hB5);

        // seed 0x80: p=131, q=137 after 6 checks
        do_req(8'h80, "s80", 1'b0, 1'b1);
        check_eq("s80_p_const", p, 8'd131);
        check_eq("s80_q_const", q, 8'd137);
        check_eq("s80_tries_const", tries, 8'd6);

        // seed 0x7E: 255 and 253 wrap and redraw, p=251
        do_req(8'h7E, "s7e", 1'b0, 1'b1);
        check_eq("s7e_p_const", p, 8'd251);

        // stray start during a request is ignored
        do_req(8'h80, "inj", 1'b1, 1'b1);
        check_eq("inj_p_const", p, 8'd131);
        check_eq("inj_q_const", q, 8'd137);
        check_eq("inj_tries_const", tries, 8'd6);

        // asynchronous reset while waiting on the checker
        issued.delete();
        @(negedge clk); start = 1'b1; seed = 8'h80;
        @(negedge clk); start = 1'b0; seed = 8'h00;
        cyc = 0;
        while (issued.size() == 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("arst_reach_wait", cyc < 100, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_chk_start", ifc.chk_start, 1'b0);
        check_eq("arst_chk_num", ifc.chk_num, 8'd0);
        check_eq("arst_p", p, 8'd0);
        check_eq("arst_q", q, 8'd0);
        check_eq("arst_tries", tries, 8'd0);
        check_eq("arst_lfsr", dut.u_lfsr.lfsr_state, 8'hB5);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_lfsr = 8'hB5; last_p = 8'h00; last_q = 8'h00;
        n_starts_f = 0;
        do_req(8'h80, "post_rst", 1'b0, 1'b1);
        check_eq("post_rst_p_const", p, 8'd131);
        check_eq("post_rst_q_const", q, 8'd137);

        // MAX_TRIES=4 instance with an always-composite checker
        for (int r = 0; r < 2; r++) begin
            n_starts_f = 0;
            @(negedge clk); start_f = 1'b1; seed_f = 8'($urandom_range(0, 255));
            @(negedge clk); start_f = 1'b0; seed_f = 8'h00;
            cyc = 0;
            while (!fail_f && !done_f && cyc < 1000) begin
                @(negedge clk);
                cyc++;
            end
            check_eq("f_timeout", cyc >= 1000, 1'b0);
            check_eq("f_fail", fail_f, 1'b1);
            check_eq("f_done", done_f, 1'b0);
            check_eq("f_nstart", n_starts_f, 4);
            check_eq("f_tries", tries_f, 8'd4);
            check_eq("f_p", p_f, 8'd0);
            check_eq("f_q", q_f, 8'd0);
            @(negedge clk);
            check_eq("f_pulse_end", fail_f, 1'b0);
            check_eq("f_busy_end", busy_f, 1'b0);
        end

        // randomized seeds, including zero (keep current LFSR state)
        for (int r = 0; r < 200; r++) begin
            logic [7:0] sd;
            sd = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            do_req(sd, $sformatf("rnd%0d", r), 1'b0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
